// File: rtl/or_8way.sv
// or_8way: WIDTH-input OR gate plus registered y, lowest-set-bit index and popcount.
// Latency: y is combinational (0 cycles); y_q/idx_q/cnt_q(/sticky_q) lag a by 1 cycle.
// Backpressure: none; a is sampled unconditionally on every rising clk edge.
//
// Ports:
//   clk      in   1      rising-edge clock for all registered outputs
//   rst      in   1      synchronous active-high reset (registered outputs only)
//   a        in   WIDTH  data inputs
//   y        out  1      combinational OR of a, independent of clk/rst
//   y_q      out  1      y registered
//   idx_q    out  IDXW   index of lowest set bit of a, registered (0 when a==0)
//   cnt_q    out  CNTW   number of set bits of a, registered
//   clr      in   1      (OR8WAY_STICKY_EN only) clears sticky_q
//   sticky_q out  1      (OR8WAY_STICKY_EN only) set once any bit of a was seen high
//
// Build option: define OR8WAY_STICKY_EN to add the clr input and sticky_q output.

module or_8way #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic             y,
    output logic             y_q,
    output logic [IDXW-1:0]  idx_q,
`ifdef OR8WAY_STICKY_EN
    input  logic             clr,
    output logic             sticky_q,
`endif
    output logic [CNTW-1:0]  cnt_q
);

    logic            y_d;
    logic [IDXW-1:0] idx_d;
    logic [CNTW-1:0] cnt_d;

    // Plain gate path: no dependency on clk or rst so it can stand in for a
    // bare OR gate.
    assign y   = |a;
    assign y_d = |a;

    // Scan from the top bit down so the last hit written is the lowest set
    // bit; an all-zero vector leaves the default of 0.
    always_comb begin
        idx_d = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (a[i]) begin
                idx_d = IDXW'(i);
            end
        end
    end

    // Popcount; CNTW is sized to hold WIDTH itself (all ones).
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d = cnt_d + CNTW'(a[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= 1'b0;
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            y_q   <= y_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef OR8WAY_STICKY_EN
    logic sticky_d;

    // Clear wins over a simultaneous set; reset wins over both.
    always_comb begin
        sticky_d = sticky_q | y_d;
        if (clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end
`endif

endmodule

// File: tb/tb_or_8way.sv
// tb_or_8way: vector table + randomized check of or_8way against a reference model.
// Latency: registered outputs checked 1 ns after the edge following each stimulus.
// Backpressure: none; a fresh stimulus is applied every cycle.

module tb_or_8way;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic       y;
    logic       y_q;
    logic [2:0] idx_q;
    logic [3:0] cnt_q;
`ifdef OR8WAY_STICKY_EN
    logic       clr;
    logic       sticky_q;
`endif

    int n_cmp;
    int n_fail;

    or_8way #(.WIDTH(8), .IDXW(3), .CNTW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .y        (y),
        .y_q      (y_q),
        .idx_q    (idx_q),
`ifdef OR8WAY_STICKY_EN
        .clr      (clr),
        .sticky_q (sticky_q),
`endif
        .cnt_q    (cnt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] a;
        logic       y;
        logic       y_q;
        logic [2:0] idx;
        logic [3:0] cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model from the arithmetic definitions.
    function automatic logic [2:0] ref_idx(input logic [7:0] v);
        logic [7:0] iso;
        if (v == 8'd0) return 3'd0;
        iso = v & (~v + 8'd1);          // isolate lowest set bit
        return 3'($clog2(iso));
    endfunction

    function automatic logic [3:0] ref_cnt(input logic [7:0] v);
        return 4'($countones(v));
    endfunction

    vec_t vecs[10];

    initial begin
        logic       e_yq;
        logic [2:0] e_idx;
        logic [3:0] e_cnt;
        logic       e_sticky;

        n_cmp  = 0;
        n_fail = 0;

        //           rst   a      y  y_q idx cnt
        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[1] = '{1'b0, 8'h01, 1'b1, 1'b1, 3'd0, 4'd1};
        vecs[2] = '{1'b0, 8'h55, 1'b1, 1'b1, 3'd0, 4'd4};
        vecs[3] = '{1'b0, 8'hAA, 1'b1, 1'b1, 3'd1, 4'd4};
        vecs[4] = '{1'b0, 8'h0F, 1'b1, 1'b1, 3'd0, 4'd4};
        vecs[5] = '{1'b0, 8'hFF, 1'b1, 1'b1, 3'd0, 4'd8};
        vecs[6] = '{1'b0, 8'h80, 1'b1, 1'b1, 3'd7, 4'd1};
        vecs[7] = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 4'd0};
        vecs[8] = '{1'b0, 8'h40, 1'b1, 1'b1, 3'd6, 4'd1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 4'd0};

        rst = 1'b1;
        a   = 8'h00;
`ifdef OR8WAY_STICKY_EN
        clr = 1'b0;
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y_q",   32'(y_q),   32'd0);
        chk("reset_idx_q", 32'(idx_q), 32'd0);
        chk("reset_cnt_q", 32'(cnt_q), 32'd0);
`ifdef OR8WAY_STICKY_EN
        chk("reset_sticky_q", 32'(sticky_q), 32'd0);
`endif

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            a   = vecs[i].a;
            #1;
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_y_q", i),   32'(y_q),   32'(vecs[i].y_q));
            chk($sformatf("vec%0d_idx_q", i), 32'(idx_q), 32'(vecs[i].idx));
            chk($sformatf("vec%0d_cnt_q", i), 32'(cnt_q), 32'(vecs[i].cnt));
        end

        // y is combinational even while reset is held.
        @(negedge clk);
        rst = 1'b1;
        a   = 8'h10;
        #1;
        chk("y_during_rst", 32'(y), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_cnt_q", 32'(cnt_q), 32'd0);

        // Registered outputs hold the previous sample until the next edge.
        @(negedge clk);
        rst = 1'b0;
        a   = 8'h80;
        @(posedge clk);
        @(negedge clk);
        a = 8'h03;
        #1;
        chk("hold_idx_q", 32'(idx_q), 32'd7);
        chk("hold_cnt_q", 32'(cnt_q), 32'd1);
        chk("hold_y",     32'(y),     32'd1);
        @(posedge clk);
        #1;
        chk("lat_idx_q", 32'(idx_q), 32'd0);
        chk("lat_cnt_q", 32'(cnt_q), 32'd2);

`ifdef OR8WAY_STICKY_EN
        // Sticky: set, hold, clear; clear beats a simultaneous set.
        @(negedge clk);
        rst = 1'b1;
        a   = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        a   = 8'h01;
        @(negedge clk);
        a = 8'h00;
        #1;
        chk("sticky_set", 32'(sticky_q), 32'd1);
        @(negedge clk);
        chk("sticky_hold", 32'(sticky_q), 32'd1);
        clr = 1'b1;
        a   = 8'hFF;
        @(negedge clk);
        clr = 1'b0;
        a   = 8'h00;
        chk("sticky_clr", 32'(sticky_q), 32'd0);
        e_sticky = 1'b0;
`else
        e_sticky = 1'b0;
`endif

        // Randomized stimulus against the reference model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            a   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = a & 8'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'h00;
            rst = ($urandom_range(0, 15) == 0);
`ifdef OR8WAY_STICKY_EN
            clr = ($urandom_range(0, 7) == 0);
            if (rst || clr) e_sticky = 1'b0;
            else            e_sticky = e_sticky | (a != 8'h00);
`endif
            e_yq  = rst ? 1'b0 : (a != 8'h00);
            e_idx = rst ? 3'd0 : ref_idx(a);
            e_cnt = rst ? 4'd0 : ref_cnt(a);
            #1;
            chk("rand_y", 32'(y), 32'(a != 8'h00));
            @(posedge clk);
            #1;
            chk("rand_y_q",   32'(y_q),   32'(e_yq));
            chk("rand_idx_q", 32'(idx_q), 32'(e_idx));
            chk("rand_cnt_q", 32'(cnt_q), 32'(e_cnt));
            chk("rand_invariant", 32'(y_q), 32'(cnt_q != 4'd0));
`ifdef OR8WAY_STICKY_EN
            chk("rand_sticky_q", 32'(sticky_q), 32'(e_sticky));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
